// File: rtl/ex_mul_hilo.sv
// EX-stage iterative 32x32 shift-add multiplier with HI/LO registers and mfhi/mflo read port.
// Optional MUL_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module ex_mul_hilo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_valid,
  input  logic [5:0]        alu_op,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hilo_rdata
);

  localparam logic [5:0] OpMfhi = 6'd11;
  localparam logic [5:0] OpMflo = 6'd12;
  localparam logic [5:0] OpMult = 6'd13;

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [DATA_W-1:0]   mcand_q, mplier_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_q;
  logic                busy_q;

  logic                accept;
  logic                is_read;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W:0]   acc_wide;
  logic [2*DATA_W-1:0] acc_step, acc_calc, hilo_res;
  logic                last_iter, calc_end;

  assign accept  = ex_valid && (alu_op == OpMult) && (state_q == StIdle) && !flush;
  assign is_read = ex_valid && ((alu_op == OpMfhi) || (alu_op == OpMflo));

  assign a_mag = (is_signed && src_a[DATA_W-1]) ? -src_a : src_a;
  assign b_mag = (is_signed && src_b[DATA_W-1]) ? -src_b : src_b;

  // Add into the upper half with carry kept, then shift {carry, acc} right by one.
  assign sum       = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_wide  = {sum, acc_q[DATA_W-1:0]};
  assign acc_step  = (2*DATA_W)'(acc_wide >> 1);
  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

`ifdef MUL_EARLY_TERM_EN
  // Once no multiplier bits remain, the outstanding right shifts collapse into one.
  assign calc_end = last_iter || ((mplier_q >> 1) == '0);
  assign acc_calc = acc_step >> (CNT_W'(DATA_W - 1) - cnt_q);
`else
  assign calc_end = last_iter;
  assign acc_calc = acc_step;
`endif

  assign hilo_res = neg_q ? -acc_q : acc_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            neg_q    <= is_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= StCalc;
            busy_q   <= 1'b1;
          end
        end
        StCalc: begin
          if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            acc_q    <= acc_calc;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (calc_end) state_q <= StFin;
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (!flush) {hi_q, lo_q} <= hilo_res;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = (state_q == StFin) && !flush;
  // Reads wait for busy to drop, so HI/LO are never forwarded from FIN.
  assign stall = busy_q || accept || (is_read && busy_q);

  always_comb begin
    hilo_rdata = '0;
    if (state_q == StIdle) begin
      if (alu_op == OpMfhi)      hilo_rdata = hi_q;
      else if (alu_op == OpMflo) hilo_rdata = lo_q;
    end
  end

endmodule

// File: doc/ex_mul_hilo.md
Name: ex_mul_hilo

Overview:
- Execute-stage consumer of the ID-stage control word: accepts ALUOp=13 (mult/multu) and performs a 32x32 iterative shift-add multiply into HI/LO.
- Serves ALUOp=11 (mfhi, funct 010000) and ALUOp=12 (mflo, funct 010010) reads from HI/LO.
- Drives a stall back to the ID/EX pipeline registers while a multiply is in flight.
- Sits beside the single-cycle ALU in the EX stage.

Parameters:
- DATA_W, 32, operand width; HI and LO are each DATA_W bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction this cycle.
- alu_op  in  6  ALUOp from ID control; 13=mult, 11=mfhi, 12=mflo; all other codes are ignored.
- is_signed  in  1  1=mult (funct 011000), 0=multu (funct 011001); sampled only on accept.
- src_a  in  DATA_W  rs operand.
- src_b  in  DATA_W  rt operand.
- flush  in  1  synchronous abort from branch/exception logic.
- stall  out  1  hold ID/EX; combinational.
- busy  out  1  multiply in flight (registered).
- done  out  1  one-cycle pulse when HI/LO are updated.
- hilo_rdata  out  DATA_W  HI (op 11) or LO (op 12); 0 for other ops.

Behaviour:
- Reset (async, resetn=0): state=IDLE; HI=0, LO=0, counter=0; busy=0, done=0. stall and hilo_rdata evaluate from reset state, giving 0.
- States: IDLE, CALC, FIN.
- IDLE -> CALC: when ex_valid && alu_op==13 && !flush. Accept cycle T0 latches:
  - |src_a| into multiplicand, |src_b| into multiplier shift register (absolute value only when is_signed=1);
  - neg = is_signed & (src_a[31]^src_b[31]);
  - clears the 64-bit accumulator; counter=0.
- CALC: each cycle:
  - if multiplier[0], add multiplicand into accumulator bits [63:32] (33-bit carry kept);
  - shift {carry, acc} right 1; shift multiplier right 1; counter++.
  - After DATA_W iterations (counter==DATA_W-1 on the last), go to FIN.
- FIN (1 cycle): {HI,LO} = neg ? -acc : acc (64-bit two's complement); done=1; next state IDLE.
- Latency: accept at T0; CALC covers T1..T32; FIN at T33; HI/LO visible at T34. busy=1 during T1..T33.
- stall = busy | (ex_valid && alu_op==13 && state==IDLE && !flush) | (ex_valid && (alu_op==11 || alu_op==12) && busy).
  - The mult itself stalls in its accept cycle, so the instruction after it waits.
  - mfhi/mflo are held until HI/LO are final (no forwarding from FIN).
- hilo_rdata: combinational from HI/LO registers when state==IDLE; value is don't-care while stalled.
- mult arriving while busy: not accepted; stall stays asserted (ID holds it).
- flush in CALC/FIN: return to IDLE next cycle; HI/LO unchanged; no done pulse. flush in the accept cycle: no accept.
- resetn deasserted mid-CALC: immediate abort to IDLE; HI/LO=0.
- Edge cases:
  - 0x80000000 * 0x80000000 signed: magnitudes 2^31, result 0x40000000_00000000.
  - Any operand 0: result 0, neg ignored (-0=0).

Optional Feature:
- MUL_EARLY_TERM_EN
- Defined: in CALC, if the remaining multiplier==0, jump to FIN after applying the remaining shift in one step (acc >> (DATA_W-counter)). Latency becomes max(1, bit-length of |src_b|) + 1 cycles.
- Undefined: fixed DATA_W-cycle CALC.
- Results are bit-identical in both builds.

Test Plan:
- multu 0xFFFFFFFF*0xFFFFFFFF -> after 34 cycles HI=0xFFFFFFFE, LO=0x00000001; done pulses exactly once at T33; busy high T1..T33.
- mult signed 0xFFFFFFFE(-2) * 0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; following mfhi stalled until HI/LO final, then hilo_rdata=0xFFFFFFFF.
- mult 0x80000000*0x80000000 signed -> HI=0x40000000, LO=0; same operands multu -> HI=0x40000000, LO=0.
- Preload HI/LO via 5*7 (LO=35). Then start 3*4 and assert flush at T10 -> state IDLE at T11, no done, mflo returns 35.
- resetn low at T15 of a multiply -> busy=0, HI=LO=0 immediately. With MUL_EARLY_TERM_EN, 0x1234*0x3 completes FIN at T3 with LO=0x369C.
